video_dac_dither: RTL and testbench

VIDEO_DAC_DITHER -- requirements
Module: video_dac_dither

---
 rtl/video_dac_dither.sv | 149 ++++++++++++++
 tb/tb_video_dac_dither.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dac_dither.sv
// Palette lookup and DAC quantiser for the TV/VGA video paths.
// Define VDAC_DITHER_EN for ordered dithering; otherwise DAC codes truncate.
module video_dac_dither #(
    parameter int DAC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c3,
    input  logic             vga_on,
    input  logic             tv_blank,
    input  logic             vga_blank,
    input  logic             vga_line,
    input  logic [1:0]       plex_sel_in,
    input  logic             tv_hires,
    input  logic             vga_hires,
    input  logic [3:0]       palsel,
    input  logic [15:0]      cram_data_in,
    input  logic [7:0]       cram_addr_in,
    input  logic             cram_we,
    input  logic [7:0]       vplex_in,
    input  logic [7:0]       vgaplex,
    output logic [DAC_W-1:0] vred,
    output logic [DAC_W-1:0] vgrn,
    output logic [DAC_W-1:0] vblu,
    output logic [4:0]       vred_raw,
    output logic [4:0]       vgrn_raw,
    output logic [4:0]       vblu_raw,
    output logic             vdac_mode
);

    localparam int FRAC_W = 5 - DAC_W;

    logic [7:0]        vplex_q;
    logic              run_q;
    logic [15:0]       q_q;
    logic              blank_q;
    logic [15:0]       mem [256];
    logic [DAC_W-1:0]  vred_q;
    logic [DAC_W-1:0]  vgrn_q;
    logic [DAC_W-1:0]  vblu_q;

    logic [7:0]        plex;
    logic [7:0]        idx;
    logic              hires;
    logic              sel;
    logic              blank_src;
    logic [14:0]       pix;
    logic [FRAC_W-1:0] thr;

    always_comb begin
        plex      = vga_on ? vgaplex : vplex_q;
        hires     = vga_on ? vga_hires : tv_hires;
        sel       = vga_on ? plex_sel_in[0] : plex_sel_in[1];
        blank_src = vga_on ? vga_blank : tv_blank;
        idx       = plex;
        if (hires) begin
            idx = {palsel, sel ? plex[3:0] : plex[7:4]};
        end
    end

    // run_q holds stage 1 empty for the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vplex_q <= '0;
            run_q   <= 1'b0;
            q_q     <= '0;
            blank_q <= 1'b1;
        end else begin
            run_q <= 1'b1;
            if (c3) begin
                vplex_q <= vplex_in;
            end
            if (cram_we) begin
                mem[cram_addr_in] <= cram_data_in;
            end
            if (run_q) begin
                q_q     <= mem[idx];
                blank_q <= blank_src;
            end
        end
    end

    assign pix       = blank_q ? 15'd0 : q_q[14:0];
    assign vred_raw  = pix[14:10];
    assign vgrn_raw  = pix[9:5];
    assign vblu_raw  = pix[4:0];
    assign vdac_mode = q_q[15];

`ifdef VDAC_DITHER_EN
    logic [FRAC_W-1:0] ph_q;
    logic [FRAC_W-1:0] ph_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_q + 1'b1;
        end
    end

    always_comb begin
        ph_line = ph_q;
        if (vga_on) begin
            ph_line[FRAC_W-1] = vga_line;
        end
        for (int i = 0; i < FRAC_W; i++) begin
            thr[i] = ph_line[FRAC_W-1-i];
        end
    end
`else
    logic unused_vga_line;

    // An all-ones threshold never rounds up, leaving plain truncation
    assign thr             = '1;
    assign unused_vga_line = vga_line;
`endif

    function automatic logic [DAC_W-1:0] quant(
        input logic [4:0]        c,
        input logic [FRAC_W-1:0] t
    );
        logic [DAC_W-1:0]  hi;
        logic [FRAC_W-1:0] lo;
        hi = c[4:FRAC_W];
        lo = c[FRAC_W-1:0];
        if ((lo > t) && (hi != '1)) begin
            quant = hi + 1'b1;
        end else begin
            quant = hi;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vred_q <= '0;
            vgrn_q <= '0;
            vblu_q <= '0;
        end else begin
            vred_q <= quant(pix[14:10], thr);
            vgrn_q <= quant(pix[9:5], thr);
            vblu_q <= quant(pix[4:0], thr);
        end
    end

    assign vred = vred_q;
    assign vgrn = vgrn_q;
    assign vblu = vblu_q;

endmodule

// File: tb/tb_video_dac_dither.sv
// Scoreboard bench for video_dac_dither: directed vectors push expected
// outputs tagged with their due cycle; a negedge monitor checks them.
module tb_video_dac_dither;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c3 = 1'b0;
    logic       vga_on = 1'b0;
    logic       tv_blank = 1'b1;
    logic       vga_blank = 1'b1;
    logic       vga_line = 1'b0;
    logic [1:0] plex_sel_in = 2'b00;
    logic       tv_hires = 1'b0;
    logic       vga_hires = 1'b0;
    logic [3:0] palsel = 4'h0;
    logic [15:0] cram_data_in = 16'h0;
    logic [7:0] cram_addr_in = 8'h0;
    logic       cram_we = 1'b0;
    logic [7:0] vplex_in = 8'h0;
    logic [7:0] vgaplex = 8'h0;

    logic [1:0] vred, vgrn, vblu;
    logic [4:0] vred_raw, vgrn_raw, vblu_raw;
    logic       vdac_mode;

    logic [3:0] vred4, vgrn4, vblu4;
    logic [4:0] vred_raw4, vgrn_raw4, vblu_raw4;
    logic       vdac_mode4;

    video_dac_dither #(.DAC_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .c3(c3), .vga_on(vga_on),
        .tv_blank(tv_blank), .vga_blank(vga_blank), .vga_line(vga_line),
        .plex_sel_in(plex_sel_in), .tv_hires(tv_hires),
        .vga_hires(vga_hires), .palsel(palsel),
        .cram_data_in(cram_data_in), .cram_addr_in(cram_addr_in),
        .cram_we(cram_we), .vplex_in(vplex_in), .vgaplex(vgaplex),
        .vred(vred), .vgrn(vgrn), .vblu(vblu),
        .vred_raw(vred_raw), .vgrn_raw(vgrn_raw), .vblu_raw(vblu_raw),
        .vdac_mode(vdac_mode)
    );

    video_dac_dither #(.DAC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .c3(c3), .vga_on(vga_on),
        .tv_blank(tv_blank), .vga_blank(vga_blank), .vga_line(vga_line),
        .plex_sel_in(plex_sel_in), .tv_hires(tv_hires),
        .vga_hires(vga_hires), .palsel(palsel),
        .cram_data_in(cram_data_in), .cram_addr_in(cram_addr_in),
        .cram_we(cram_we), .vplex_in(vplex_in), .vgaplex(vgaplex),
        .vred(vred4), .vgrn(vgrn4), .vblu(vblu4),
        .vred_raw(vred_raw4), .vgrn_raw(vgrn_raw4), .vblu_raw(vblu_raw4),
        .vdac_mode(vdac_mode4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_RAW  = 0;
    localparam int K_MODE = 1;
    localparam int K_DAC  = 2;
    localparam int K_DAC4 = 3;
    localparam int K_CNT  = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [1:0] hist [8];

    task automatic expect_at(input int c, input int k,
                             input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] sample(input int k);
        int c1;
        int c2;
        c1 = 0;
        c2 = 0;
        if (k == K_RAW) return {1'b0, vred_raw, vgrn_raw, vblu_raw};
        if (k == K_MODE) return {15'd0, vdac_mode};
        if (k == K_DAC) return {10'd0, vred, vgrn, vblu};
        if (k == K_DAC4) return {4'd0, vred4, vgrn4, vblu4};
        for (int i = 0; i < 8; i++) begin
            if (hist[i] === 2'd2) c2++;
            if (hist[i] === 2'd1) c1++;
        end
        return {c2[7:0], c1[7:0]};
    endfunction

    always @(negedge clk) begin
        logic [15:0] act;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = vred;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = sample(sb[i].kind);
                n_cmp++;
                if (act !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h",
                             sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s expired at cyc=%0d want=%h",
                         sb[i].name, sb[i].cyc, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        cram_we      = 1'b1;
        cram_addr_in = a;
        cram_data_in = d;
        tick();
        cram_we = 1'b0;
    endtask

    int n;

    initial begin
        tick();
        tick();
        n = cyc;
        expect_at(n, K_RAW,  16'h0000, "reset_raw");
        expect_at(n, K_MODE, 16'h0000, "reset_mode");
        expect_at(n, K_DAC,  16'h0000, "reset_dac");
        expect_at(n, K_DAC4, 16'h0000, "reset_dac4");

        tick();
        rst_n     = 1'b1;
        vga_on    = 1'b1;
        vga_blank = 1'b0;
        vgaplex   = 8'h05;
        n = cyc;
        expect_at(n + 1, K_RAW,  16'h0000, "release_raw");
        expect_at(n + 1, K_MODE, 16'h0000, "release_mode");
        tick();

        wr(8'h05, 16'h8421);
        wr(8'h10, 16'h2C00);
        wr(8'h11, 16'h7FFF);
        wr(8'hAC, 16'h1111);
        wr(8'hA3, 16'h2222);
        wr(8'h3C, 16'h3333);
        wr(8'h77, 16'h1234);

        n = cyc;
        vgaplex = 8'h05;
        expect_at(n + 1, K_RAW,  16'h0421, "rd05_raw");
        expect_at(n + 1, K_MODE, 16'h0001, "rd05_mode");
        tick();
        vga_blank = 1'b1;
        expect_at(n + 2, K_RAW,  16'h0000, "blank05_raw");
        expect_at(n + 2, K_MODE, 16'h0001, "blank05_mode");
        tick();
        vga_blank = 1'b0;

        n = cyc;
        vga_hires   = 1'b1;
        palsel      = 4'hA;
        vgaplex     = 8'h3C;
        plex_sel_in = 2'b01;
        expect_at(n + 1, K_RAW, 16'h1111, "hires_AC");
        tick();
        plex_sel_in = 2'b10;
        expect_at(n + 2, K_RAW, 16'h2222, "hires_A3");
        tick();
        vga_hires = 1'b0;
        expect_at(n + 3, K_RAW, 16'h3333, "lores_3C");
        tick();

        n = cyc;
        cram_we      = 1'b1;
        cram_addr_in = 8'h3C;
        cram_data_in = 16'h4444;
        expect_at(n + 1, K_RAW, 16'h3333, "rdw_old");
        tick();
        cram_we = 1'b0;
        expect_at(n + 2, K_RAW, 16'h4444, "rdw_new");
        tick();

        n = cyc;
        vga_on   = 1'b0;
        tv_blank = 1'b0;
        c3       = 1'b1;
        vplex_in = 8'h10;
        expect_at(n + 2, K_RAW, 16'h2C00, "tv_raw_10");
`ifdef VDAC_DITHER_EN
        expect_at(n + 10, K_CNT, 16'h0305, "dither_count");
`else
        expect_at(n + 10, K_CNT, 16'h0008, "trunc_count");
`endif
        for (int i = 0; i < 11; i++) tick();

        n = cyc;
        vplex_in = 8'h11;
        expect_at(n + 2, K_RAW, 16'h7FFF, "tv_raw_11");
        for (int i = 3; i < 9; i++) begin
            expect_at(n + i, K_DAC,  16'h003F, "sat_dac2");
            expect_at(n + i, K_DAC4, 16'h0FFF, "sat_dac4");
        end
        for (int i = 0; i < 9; i++) tick();

        vga_on    = 1'b1;
        vga_blank = 1'b0;
        vgaplex   = 8'h11;
        tick();
        tick();
        n = cyc;
        vga_blank = 1'b1;
        expect_at(n,     K_RAW, 16'h7FFF, "bp_raw_pre");
        expect_at(n + 1, K_RAW, 16'h0000, "bp_raw_blank");
        expect_at(n + 2, K_RAW, 16'h7FFF, "bp_raw_post");
        expect_at(n + 3, K_RAW, 16'h7FFF, "bp_raw_post2");
        expect_at(n + 1, K_DAC, 16'h003F, "bp_dac_pre");
        expect_at(n + 2, K_DAC, 16'h0000, "bp_dac_blank");
        expect_at(n + 3, K_DAC, 16'h003F, "bp_dac_post");
        tick();
        vga_blank = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        n = cyc;
        rst_n        = 1'b0;
        cram_we      = 1'b1;
        cram_addr_in = 8'h77;
        cram_data_in = 16'h7FFF;
        expect_at(n, K_RAW,  16'h0000, "midrst_raw");
        expect_at(n, K_MODE, 16'h0000, "midrst_mode");
        expect_at(n, K_DAC,  16'h0000, "midrst_dac");
        expect_at(n, K_DAC4, 16'h0000, "midrst_dac4");
        tick();
        cram_we = 1'b0;
        expect_at(n + 1, K_RAW, 16'h0000, "midrst_raw2");
        tick();
        rst_n   = 1'b1;
        vgaplex = 8'h77;
        expect_at(n + 3, K_RAW,  16'h0000, "rel2_raw");
        expect_at(n + 3, K_MODE, 16'h0000, "rel2_mode");
        expect_at(n + 3, K_DAC,  16'h0000, "rel2_dac");
        tick();
        expect_at(n + 4, K_RAW,  16'h1234, "kept_77");
        expect_at(n + 4, K_MODE, 16'h0000, "kept_77_mode");
        tick();
        vgaplex = 8'h05;
        expect_at(n + 5, K_RAW,  16'h0421, "kept_05");
        expect_at(n + 5, K_MODE, 16'h0001, "kept_05_mode");
        for (int i = 0; i < 4; i++) tick();

        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked want=%h", sb[0].name, sb[0].val);
            sb.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
